// File: rtl/trivium_pkg.sv
// Shared constants, FSM state type and tap positions for the bit-serial Trivium engine.
// Tap and register-boundary indices follow the 1-based s[1..288] numbering of the cipher.
package trivium_pkg;

    localparam int KEY_BITS      = 80;
    localparam int IV_BITS       = 80;
    localparam int LOAD_BITS     = KEY_BITS + IV_BITS;
    localparam int WARMUP_CYCLES = 1152;
    localparam int STATE_BITS    = 288;

    localparam int LOAD_CNT_W = $clog2(LOAD_BITS + 1);
    localparam int WARM_CNT_W = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARMUP,
        RUN
    } state_t;

    // Linear taps, AND-pair taps and cross-register feedback tap per register.
    localparam int T1_A = 66;
    localparam int T1_B = 93;
    localparam int T1_P = 91;
    localparam int T1_Q = 92;
    localparam int T1_X = 171;
    localparam int T2_A = 162;
    localparam int T2_B = 177;
    localparam int T2_P = 175;
    localparam int T2_Q = 176;
    localparam int T2_X = 264;
    localparam int T3_A = 243;
    localparam int T3_B = 288;
    localparam int T3_P = 286;
    localparam int T3_Q = 287;
    localparam int T3_X = 69;

    localparam int IV_BASE = 94;

    // Everything cleared except s[286..288], which the cipher fixes to one.
    localparam logic [STATE_BITS:1] LOAD_INIT = {3'b111, {(STATE_BITS - 3){1'b0}}};

    // Serial load index that lands in state bit pos, or -1 if pos is never loaded.
    function automatic int load_index(input int pos);
        if (pos >= 1 && pos <= KEY_BITS)
            return pos - 1;
        else if (pos >= IV_BASE && pos < IV_BASE + IV_BITS)
            return pos - IV_BASE + KEY_BITS;
        else
            return -1;
    endfunction

endpackage

// File: rtl/trivium_core.sv
// 288-bit Trivium state with one-round-per-clock update and a serial load port.
// load_start reinitialises the state in the same cycle as the first load write.
module trivium_core
    import trivium_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  load_start,
    input  logic                  load_wr,
    input  logic [LOAD_CNT_W-1:0] load_idx,
    input  logic                  load_bit,
    input  logic                  round_en,
    output logic                  z
);

    logic [STATE_BITS:1] s_reg;
    logic [STATE_BITS:1] s_next;
    logic [STATE_BITS:1] s_round;
    logic [STATE_BITS:1] s_base;
    logic                t1;
    logic                t2;
    logic                t3;
    logic                f1;
    logic                f2;
    logic                f3;

    always_comb begin
        t1 = s_reg[T1_A] ^ s_reg[T1_B];
        t2 = s_reg[T2_A] ^ s_reg[T2_B];
        t3 = s_reg[T3_A] ^ s_reg[T3_B];
        z  = t1 ^ t2 ^ t3;
        f1 = t1 ^ (s_reg[T1_P] & s_reg[T1_Q]) ^ s_reg[T1_X];
        f2 = t2 ^ (s_reg[T2_P] & s_reg[T2_Q]) ^ s_reg[T2_X];
        f3 = t3 ^ (s_reg[T3_P] & s_reg[T3_Q]) ^ s_reg[T3_X];
        // Three shift registers, each fed at its low end by the previous one's feedback.
        s_round = {s_reg[287:178], f2, s_reg[176:94], f1, s_reg[92:1], f3};
        s_base  = load_start ? LOAD_INIT : s_reg;
    end

    for (genvar gi = 1; gi <= STATE_BITS; gi++) begin : g_bit
        localparam int N = load_index(gi);
        if (N >= 0) begin : g_ld
            assign s_next[gi] = (load_wr && load_idx == LOAD_CNT_W'(N)) ? load_bit :
                                round_en ? s_round[gi] : s_base[gi];
        end else begin : g_nl
            assign s_next[gi] = round_en ? s_round[gi] : s_base[gi];
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            s_reg <= '0;
        else
            s_reg <= s_next;
    end

endmodule

// File: rtl/trivium_top.sv
// Bit-serial Trivium encrypt/decrypt engine: serial key/IV load, warm-up, then dat_o = dat_i ^ z.
// Defining KEYSTREAM_OUT_EN adds ks_o, the registered raw keystream bit.
module trivium_top
    import trivium_pkg::*;
(
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic dat_i,
    input  logic init_i,
    input  logic end_i,
    output logic dat_o,
    output logic busy_init_o
`ifdef KEYSTREAM_OUT_EN
    ,
    output logic ks_o
`endif
);

    state_t                state_reg;
    state_t                state_next;
    logic [LOAD_CNT_W-1:0] load_cnt_reg;
    logic [WARM_CNT_W-1:0] warm_cnt_reg;
    logic                  dat_reg;
    logic                  load_start;
    logic                  load_wr;
    logic [LOAD_CNT_W-1:0] load_idx;
    logic                  round_en;
    logic                  run_out;
    logic                  z;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (end_i) begin
            state_next = IDLE;
        end else if (init_i && state_reg != LOAD) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE:   state_next = IDLE;
                LOAD:   if (!init_i)
                            state_next = (load_cnt_reg == LOAD_CNT_W'(LOAD_BITS)) ? WARMUP : IDLE;
                WARMUP: if (warm_cnt_reg == WARM_CNT_W'(WARMUP_CYCLES - 1))
                            state_next = RUN;
                RUN:    state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        load_start  = !end_i && init_i && state_reg != LOAD;
        load_wr     = load_start ||
                      (state_reg == LOAD && !end_i && init_i &&
                       load_cnt_reg < LOAD_CNT_W'(LOAD_BITS));
        load_idx    = load_start ? '0 : load_cnt_reg;
        round_en    = !end_i && !init_i && (state_reg == WARMUP || state_reg == RUN);
        run_out     = round_en && state_reg == RUN;
        busy_init_o = state_reg == WARMUP;
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            load_cnt_reg <= '0;
            warm_cnt_reg <= '0;
        end else begin
            if (load_start)
                load_cnt_reg <= LOAD_CNT_W'(1);
            else if (load_wr)
                load_cnt_reg <= load_cnt_reg + 1'b1;
            else if (state_next == IDLE)
                load_cnt_reg <= '0;
            warm_cnt_reg <= (state_reg == WARMUP && state_next == WARMUP) ?
                            warm_cnt_reg + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            dat_reg <= 1'b0;
        else
            dat_reg <= run_out ? (dat_i ^ z) : 1'b0;
    end

    assign dat_o = dat_reg;

`ifdef KEYSTREAM_OUT_EN
    logic ks_reg;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            ks_reg <= 1'b0;
        else
            ks_reg <= run_out ? z : 1'b0;
    end

    assign ks_o = ks_reg;
`endif

    trivium_core u_core (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_start (load_start),
        .load_wr    (load_wr),
        .load_idx   (load_idx),
        .load_bit   (dat_i),
        .round_en   (round_en),
        .z          (z)
    );

endmodule

// File: tb/tb_trivium_top.sv
// Scoreboard bench for trivium_top: the driver queues expected outputs, a negedge monitor checks them.
module tb_trivium_top;

    logic clk_i = 1'b0;
    logic n_rst_i;
    logic dat_i;
    logic init_i;
    logic end_i;
    logic dat_o;
    logic busy_init_o;
`ifdef KEYSTREAM_OUT_EN
    logic ks_o;
`endif

    always #5 clk_i = ~clk_i;

    trivium_top dut (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .dat_i       (dat_i),
        .init_i      (init_i),
        .end_i       (end_i),
        .dat_o       (dat_o),
        .busy_init_o (busy_init_o)
`ifdef KEYSTREAM_OUT_EN
        ,
        .ks_o        (ks_o)
`endif
    );

    typedef struct {
        int    due;
        bit    kind;
        bit    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   ms[1:288];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: kind 0 checks dat_o, kind 1 checks busy_init_o.
    always @(negedge clk_i) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            bit   act;
            e   = q.pop_front();
            act = e.kind ? busy_init_o : dat_o;
            tests++;
            if (e.due != cyc || act !== e.val) begin
                fails++;
                $display("[TB] FAIL %s cyc=%0d due=%0d got=%b want=%b", e.name, cyc, e.due, act, e.val);
            end
        end
    end

    function automatic bit m_round();
        bit t1, t2, t3, zz;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        zz = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int k = 288; k >= 179; k--) ms[k] = ms[k-1];
        ms[178] = t2;
        for (int k = 177; k >= 95; k--) ms[k] = ms[k-1];
        ms[94] = t1;
        for (int k = 93; k >= 2; k--) ms[k] = ms[k-1];
        ms[1] = t3;
        return zz;
    endfunction

    task automatic push(input bit kind, input bit val, input string name);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input bit i, input bit e, input bit d);
        @(negedge clk_i);
        init_i = i;
        end_i  = e;
        dat_i  = d;
    endtask

    task automatic idle_check(input int n, input bit e, input string name);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, e, k[0]);
            push(1'b0, 1'b0, name);
            push(1'b1, 1'b0, name);
        end
    endtask

    // Full 160-bit load, then 1152 warm-up cycles with busy_init_o tracked cycle by cycle.
    task automatic load(input bit [79:0] key, input bit [79:0] iv, input string tag);
        bit b;
        for (int k = 1; k <= 288; k++) ms[k] = (k >= 286);
        for (int n = 0; n < 160; n++) begin
            b = (n < 80) ? key[n] : iv[n-80];
            drive(1'b1, 1'b0, b);
            push(1'b0, 1'b0, "load_dat");
            if (n < 80) ms[n+1] = b;
            else        ms[n+14] = b;
        end
        drive(1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b1, "busy_rise");
        push(1'b0, 1'b0, "drop_dat");
        for (int k = 0; k < 1152; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            push(1'b1, (k < 1151), (k < 1151) ? "busy_warm" : "busy_fall");
            push(1'b0, 1'b0, "warm_dat");
            void'(m_round());
        end
        $display("[TB] session %s loaded key=%h iv=%h", tag, key, iv);
    endtask

    // One 32-bit word LSB-first; use_ref selects a fixed expected word instead of the model.
    task automatic run_word(input bit [31:0] din, input bit use_ref, input bit [31:0] ref_w,
                            output bit [31:0] dout);
        bit o;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, din[i]);
            o       = din[i] ^ m_round();
            dout[i] = o;
            push(1'b0, use_ref ? ref_w[i] : o, use_ref ? "decrypt" : "encrypt");
        end
        $display("[TB] word in=%h out=%h", din, use_ref ? ref_w : dout);
    endtask

    bit [31:0] pt [4] = '{32'hDEADBEEF, 32'h01234567, 32'hFFFFFFFF, 32'h00000000};
    bit [31:0] ct [4];
    bit [31:0] w;
    localparam bit [79:0] KEY1 = 80'h8000_0000_0000_0000_0000;
    localparam bit [79:0] KEY2 = 80'h0123_4567_89AB_CDEF_1357;
    localparam bit [79:0] IV2  = 80'hA5A5_0F0F_3C3C_FFFF_0001;

    initial begin
        n_rst_i = 1'b0;
        init_i  = 1'b0;
        end_i   = 1'b0;
        dat_i   = 1'b0;

        idle_check(3, 1'b0, "reset_hold");
        n_rst_i = 1'b1;
        idle_check(10, 1'b0, "post_reset");
        $display("[TB] reset sequence done");

        load(80'h0, 80'h0, "zero");
        for (int k = 0; k < 8; k++) run_word(32'h0, 1'b0, 32'h0, w);

        load(KEY1, 80'h0, "key1_enc");
        for (int k = 0; k < 4; k++) begin
            run_word(pt[k], 1'b0, 32'h0, w);
            ct[k] = w;
        end
        drive(1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, "end_dat");
        push(1'b1, 1'b0, "end_busy");
        idle_check(5, 1'b0, "after_end");
        $display("[TB] end_i during run done");

        load(KEY1, 80'h0, "key1_dec");
        for (int k = 0; k < 4; k++) run_word(ct[k], 1'b1, pt[k], w);

        load(KEY2, IV2, "restart");
        for (int k = 0; k < 2; k++) run_word(pt[k], 1'b0, 32'h0, w);

        drive(1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, "end2_dat");
        for (int n = 0; n < 100; n++) begin
            drive(1'b1, 1'b0, n[0]);
            push(1'b0, 1'b0, "short_load");
        end
        idle_check(20, 1'b0, "short_abort");
        $display("[TB] short load abort done");

        load(KEY2, IV2, "reset_mid");
        run_word(pt[0], 1'b0, 32'h0, w);
        drive(1'b0, 1'b0, 1'b1);
        n_rst_i = 1'b0;
        push(1'b0, 1'b0, "rst_mid_dat");
        push(1'b1, 1'b0, "rst_mid_busy");
        idle_check(2, 1'b0, "rst_mid_hold");
        n_rst_i = 1'b1;
        idle_check(5, 1'b0, "rst_mid_idle");
        $display("[TB] mid-run reset done");

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain pending=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
